fir_result_serializer: RTL and testbench

//  Downstream stage of the FIR core. Captures each FIR_Output word qualified by Output_Valid.

---
 rtl/fir_result_serializer_pkg.sv | 19 +
 rtl/fir_result_serializer_if.sv | 28 ++
 rtl/fir_result_serializer_fifo.sv | 55 +++++
 rtl/fir_result_serializer.sv | 107 ++++++++++
 tb/tb_fir_result_serializer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_result_serializer_pkg.sv
// Shared constants, FSM state encoding and byte-count helper for the FIR result serializer.
package fir_result_serializer_pkg;

    localparam int BYTE_W           = 8;
    localparam int OUTPUT_WIDTH_DEF = 38;
    localparam int FIFO_DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    function automatic int byte_count(input int width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/fir_result_serializer_if.sv
// Bundle of FIR-side capture, UART-side handshake and status signals of the serializer.
interface fir_result_serializer_if
    import fir_result_serializer_pkg::*;
#(
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
);
    // Output_Valid is a one-cycle strobe with no backpressure. tx_start is a one-cycle
    // pulse issued only while tx_busy=0; the byte counts as taken once tx_busy rises.
    logic                          Output_Valid;
    logic [OUTPUT_WIDTH-1:0]       FIR_Output;
    logic                          tx_busy;
    logic                          tx_start;
    logic [BYTE_W-1:0]             tx_data;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    state_t                        dbg_state;

    modport slave (
        input  Output_Valid, FIR_Output, tx_busy,
        output tx_start, tx_data, overflow, fifo_count, dbg_state
    );

    modport master (
        output Output_Valid, FIR_Output, tx_busy,
        input  tx_start, tx_data, overflow, fifo_count, dbg_state
    );
endinterface

// File: rtl/fir_result_serializer_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module fir_result_serializer_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/fir_result_serializer.sv
// Buffers FIR results, sign-extends them to whole bytes and sends them LSB-first to the UART.
module fir_result_serializer
    import fir_result_serializer_pkg::*;
#(
    parameter int output_width = OUTPUT_WIDTH_DEF,
    parameter int fifo_depth   = FIFO_DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    fir_result_serializer_if.slave bus
);
    localparam int BC = byte_count(output_width);
    localparam int SW = BC * BYTE_W;
    localparam int IW = $clog2(BC + 1);
    localparam int CW = $clog2(fifo_depth) + 1;

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_shift;
    logic [IW-1:0]     r_byte_idx;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_overflow;
    logic              w_pop;
    logic              w_tx_start;
    logic              w_shift_en;
    logic              w_full;
    logic              w_empty;
    logic [SW-1:0]     w_ext;
    logic [SW-1:0]     w_head;
    logic [CW-1:0]     w_count;

    assign w_ext = SW'($signed(bus.FIR_Output));

    fir_result_serializer_fifo #(
        .WIDTH (SW),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (bus.Output_Valid),
        .i_pop   (w_pop),
        .i_wdata (w_ext),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_tx_start = 1'b0;
        w_shift_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy && !reset) begin
                    w_tx_start = 1'b1;
                    w_next     = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (bus.tx_busy) w_next = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    w_shift_en = 1'b1;
                    w_next     = (r_byte_idx == IW'(BC - 1)) ? ST_IDLE : ST_SEND;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A word is lost only when the FIFO is full and the FSM is not draining it this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_shift    <= w_head;
                r_byte_idx <= '0;
            end else if (w_shift_en) begin
                r_shift    <= r_shift >> BYTE_W;
                r_byte_idx <= r_byte_idx + IW'(1);
            end
            if (w_tx_start) r_tx_data <= r_shift[BYTE_W-1:0];
            if (bus.Output_Valid && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign bus.tx_start   = w_tx_start;
    assign bus.tx_data    = w_tx_start ? r_shift[BYTE_W-1:0] : r_tx_data;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = w_count;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fir_result_serializer.sv
// Directed scoreboard bench for fir_result_serializer with a simple UART busy model.
module tb_fir_result_serializer;
    import fir_result_serializer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   starts = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    logic prev_start = 1'b0;
    logic [7:0] exp_q[$];

    fir_result_serializer_if #(.OUTPUT_WIDTH(38), .FIFO_DEPTH(4)) bus ();

    fir_result_serializer #(.output_width(38), .fifo_depth(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // UART model: busy from the cycle after tx_start for 10 cycles
    always @(posedge clock) begin
        if (bus.tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = force_busy | (busy_cnt != 0);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && bus.tx_start) begin
            starts = starts + 1;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            total = total + 1;
            if (prev_start) begin
                bad = bad + 1;
                $display("FAIL back_to_back_start: tx_start high in consecutive cycles at cyc %0d", cyc);
            end
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_start: tx_data=%02h, required no byte", bus.tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    bad = bad + 1;
                    $display("FAIL tx_byte: actual=%02h required=%02h", bus.tx_data, e);
                end
            end
        end
        prev_start = bus.tx_start;
    end

    // driver / helper tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [39:0] le);
        for (int i = 0; i < 5; i++) exp_q.push_back(le[8*i +: 8]);
    endtask

    task automatic send_word(input logic [37:0] v, output int t);
        @(posedge clock);
        #1;
        bus.Output_Valid = 1'b1;
        bus.FIR_Output   = v;
        t = cyc;
        @(posedge clock);
        #1;
        bus.Output_Valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clock);
            #1;
            if (bus.dbg_state == s) done = 1'b1;
        end
        if (!done) check("wait_state_timeout", 64'(bus.dbg_state), 64'(s));
    endtask

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0 && bus.dbg_state == ST_IDLE &&
                bus.fifo_count == 0 && busy_cnt == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int t;
        int s0;
        bus.Output_Valid = 1'b0;
        bus.FIR_Output   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clock);
        check("rst_tx_start", 64'(bus.tx_start), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));

        // 1: negative value, latency t+2, five pulses
        s0 = starts;
        first_cyc = -1;
        expect_word(40'hFF_FFFF_FFFB);
        send_word(38'h3F_FFFF_FFFB, t);
        wait_drain(400);
        check("t1_latency", 64'(first_cyc - t), 64'd2);
        check("t1_start_count", 64'(starts - s0), 64'd5);
        check("t1_overflow", 64'(bus.overflow), 64'd0);

        // 2: two words back to back, second queued during the first
        first_cyc = -1;
        expect_word(40'h1F_0102_0304);
        send_word(38'h1F_0102_0304, t);
        repeat (5) @(posedge clock);
        expect_word(40'h00_0000_0001);
        send_word(38'h00_0000_0001, t);
        wait_drain(400);
        check("t2_span", 64'(last_cyc - first_cyc), 64'd109);

        // 3: UART stalled; one word in flight, four buffered, sixth dropped
        force_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) expect_word(40'(i));
            send_word(38'(i), t);
        end
        @(negedge clock);
        check("t3_fifo_count", 64'(bus.fifo_count), 64'd4);
        check("t3_overflow", 64'(bus.overflow), 64'd1);
        @(posedge clock);
        #1;
        force_busy = 1'b0;
        wait_drain(1000);
        check("t3_overflow_sticky", 64'(bus.overflow), 64'd1);

        // 4: push into full FIFO in the same cycle as the IDLE pop
        do_reset();
        force_busy = 1'b1;
        expect_word(40'h00_0000_00A1);
        send_word(38'h00_0000_00A1, t);
        for (int i = 2; i <= 5; i++) begin
            expect_word(40'(8'hA0 + i));
            send_word(38'(8'hA0 + i), t);
        end
        @(posedge clock);
        #1;
        force_busy = 1'b0;
        wait_state(ST_IDLE, 300);
        check("t4_full_before", 64'(bus.fifo_count), 64'd4);
        bus.Output_Valid = 1'b1;
        bus.FIR_Output   = 38'h00_0000_00A6;
        expect_word(40'h00_0000_00A6);
        @(posedge clock);
        #1;
        bus.Output_Valid = 1'b0;
        @(negedge clock);
        check("t4_fifo_count", 64'(bus.fifo_count), 64'd4);
        check("t4_overflow", 64'(bus.overflow), 64'd0);
        wait_drain(1000);

        // 5: reset mid-word with three words queued
        force_busy = 1'b1;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0C);
        send_word(38'h00_0A0B_0C0D, t);
        for (int i = 7; i <= 9; i++) send_word(38'(i), t);
        @(negedge clock);
        check("t5_queued", 64'(bus.fifo_count), 64'd3);
        @(posedge clock);
        #1;
        force_busy = 1'b0;
        s0 = starts;
        for (int i = 0; i < 100 && starts < s0 + 2; i++) @(posedge clock);
        check("t5_two_bytes", 64'(starts - s0), 64'd2);
        repeat (3) @(posedge clock);
        do_reset();
        @(negedge clock);
        check("t5_tx_start", 64'(bus.tx_start), 64'd0);
        check("t5_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("t5_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        s0 = starts;
        repeat (60) @(posedge clock);
        check("t5_quiet", 64'(starts - s0), 64'd0);

        // 6: busy already high on entry to SEND
        force_busy = 1'b1;
        expect_word(40'hE0_0000_0080);
        send_word(38'h20_0000_0080, t);
        wait_state(ST_SEND, 20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_held", 64'(bus.tx_start), 64'd0);
        end
        @(posedge clock);
        #1;
        force_busy = 1'b0;
        @(negedge clock);
        check("t6_start_after_fall", 64'(bus.tx_start), 64'd1);
        check("t6_first_byte", 64'(bus.tx_data), 64'h80);
        wait_drain(400);
        check("t6_data_hold", 64'(bus.tx_data), 64'hE0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
